rle_run_scheduler: RTL and testbench

RLE_RUN_SCHEDULER -- requirements
Module: rle_run_scheduler

---
 rtl/rle_run_scheduler_if.sv | 22 ++
 rtl/rle_run_scheduler.sv | 101 ++++++++++
 tb/tb_rle_run_scheduler.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/rle_run_scheduler_if.sv
// rle_run_scheduler_if: symbol input and token output handshakes of the run scheduler
interface rle_run_scheduler_if;
    logic [6:0] dataIn;
    logic       inValid;
    logic       inLast;
    logic       inReady;
    logic [7:0] outData;
    logic       outValid;
    logic       outTag;
    logic       outIsCount;
    logic       outLast;
    logic       outReady;
    logic       busy;
    modport master (
        output dataIn, inValid, inLast, outReady,
        input  inReady, outData, outValid, outTag, outIsCount, outLast, busy
    );
    modport slave (
        input  dataIn, inValid, inLast, outReady,
        output inReady, outData, outValid, outTag, outIsCount, outLast, busy
    );
endinterface

// File: rtl/rle_run_scheduler.sv
// rle_run_scheduler: run-length tokenizer; each run of printable symbols becomes
// a char token, followed by a count token when the run is longer than one.
module rle_run_scheduler #(
    parameter int MAX_RUN = 255
) (
    input logic clock,
    input logic reset,
    rle_run_scheduler_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, EMIT_CHAR, EMIT_COUNT} state_t;
    localparam logic [7:0] MAX_CNT = 8'(MAX_RUN);
    state_t     state_q, state_d;
    logic [6:0] cur_q, cur_d, pend_q, pend_d;
    logic [7:0] cnt_q, cnt_d;
    logic       pend_v_q, pend_v_d, pend_last_q, pend_last_d, run_last_q, run_last_d;
    logic       in_fire, out_fire, printable, multi, resolve;
    assign in_fire   = bus.inValid && bus.inReady;
    assign out_fire  = bus.outValid && bus.outReady;
    assign printable = bus.dataIn >= 7'd32;
    assign multi     = cnt_q >= 8'd2;
    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        cnt_d       = cnt_q;
        pend_d      = pend_q;
        pend_v_d    = pend_v_q;
        pend_last_d = pend_last_q;
        run_last_d  = run_last_q;
        resolve     = 1'b0;
        case (state_q)
            IDLE: if (in_fire && printable) begin
                cur_d      = bus.dataIn;
                cnt_d      = 8'd1;
                run_last_d = bus.inLast;
                state_d    = bus.inLast ? EMIT_CHAR : RUN;
            end
            RUN: if (in_fire) begin
                if (!printable) begin
                    if (bus.inLast) begin
                        run_last_d = 1'b1;
                        state_d    = EMIT_CHAR;
                    end
                end else if (bus.dataIn == cur_q) begin
                    cnt_d      = cnt_q + 8'd1;
                    run_last_d = bus.inLast;
                    state_d    = (cnt_d == MAX_CNT || bus.inLast) ? EMIT_CHAR : RUN;
                end else begin
                    pend_d      = bus.dataIn;
                    pend_v_d    = 1'b1;
                    pend_last_d = bus.inLast;
                    run_last_d  = 1'b0;
                    state_d     = EMIT_CHAR;
                end
            end
            EMIT_CHAR: if (out_fire) begin
                state_d = multi ? EMIT_COUNT : state_q;
                resolve = !multi;
            end
            EMIT_COUNT: resolve = out_fire;
            default: state_d = IDLE;
        endcase
        // the symbol that broke the previous run becomes the new open run
        if (resolve) begin
            if (pend_v_q) begin
                cur_d      = pend_q;
                cnt_d      = 8'd1;
                pend_v_d   = 1'b0;
                run_last_d = pend_last_q;
                state_d    = pend_last_q ? EMIT_CHAR : RUN;
            end else begin
                state_d = IDLE;
            end
        end
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cur_q       <= '0;
            cnt_q       <= '0;
            pend_q      <= '0;
            pend_v_q    <= 1'b0;
            pend_last_q <= 1'b0;
            run_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            pend_v_q    <= pend_v_d;
            pend_last_q <= pend_last_d;
            run_last_q  <= run_last_d;
        end
    end
    assign bus.inReady    = state_q == IDLE || state_q == RUN;
    assign bus.outValid   = state_q == EMIT_CHAR || state_q == EMIT_COUNT;
    assign bus.outData    = state_q == EMIT_CHAR ? {1'b0, cur_q} : state_q == EMIT_COUNT ? cnt_q : 8'd0;
    assign bus.outTag     = state_q == EMIT_CHAR && multi;
    assign bus.outIsCount = state_q == EMIT_COUNT;
    assign bus.outLast    = run_last_q && !pend_v_q && (state_q == EMIT_COUNT || (state_q == EMIT_CHAR && !multi));
    assign bus.busy       = state_q != IDLE;
endmodule

// File: tb/tb_rle_run_scheduler.sv
// tb_rle_run_scheduler: scoreboard bench; a run-length reference model queues the
// expected tokens, an independent monitor pops and compares on each output transfer.
module tb_rle_run_scheduler;
    localparam int MAXR = 4;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic rnd_ready = 1'b1;
    logic manual_ready = 1'b0;
    int   ready_mode = 0;
    int   vectors = 0;
    int   errs = 0;
    logic [10:0] q[$];
    logic [6:0]  m_ch;
    int          m_cnt;
    bit          m_open;
    logic [10:0] snap;
    bit          hold_v;

    rle_run_scheduler_if bus();
    rle_run_scheduler #(.MAX_RUN(MAXR)) dut (.clock(clock), .reset(reset), .bus(bus));

    always #5 clock = ~clock;
    assign bus.outReady = ready_mode == 0 ? 1'b1 : ready_mode == 1 ? rnd_ready : manual_ready;
    always @(negedge clock) rnd_ready = $urandom_range(0, 2) != 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // token layout: {isCount, tag, last, data}
    task automatic emit_run(input bit last);
        q.push_back({1'b0, m_cnt >= 2, last && m_cnt < 2, 1'b0, m_ch});
        if (m_cnt >= 2) q.push_back({1'b1, 1'b0, last, 8'(m_cnt)});
        m_open = 0;
    endtask

    task automatic model_accept(input logic [6:0] s, input bit l);
        if (s < 7'd32) begin
            if (l && m_open) emit_run(1);
        end else if (m_open && s == m_ch) begin
            m_cnt++;
            if (m_cnt == MAXR || l) emit_run(l);
        end else begin
            if (m_open) emit_run(0);
            m_ch = s;
            m_cnt = 1;
            m_open = 1;
            if (l) emit_run(1);
        end
    endtask

    task automatic send(input logic [6:0] s, input bit l);
        int n = 0;
        @(negedge clock);
        bus.dataIn = s;
        bus.inLast = l;
        bus.inValid = 1'b1;
        #1;
        while (!bus.inReady && n < 300) begin
            @(negedge clock);
            #1;
            n++;
        end
        if (!bus.inReady) chk("inReady timeout", 0, 1);
        else model_accept(s, l);
        @(posedge clock);
        #1;
        bus.inValid = 1'b0;
        bus.inLast = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 1000) begin
            @(negedge clock);
            n++;
        end
        chk("drain leftover tokens", q.size(), 0);
        #3;
        chk("busy after drain", bus.busy, 0);
        chk("outValid after drain", bus.outValid, 0);
    endtask

    initial begin
        hold_v = 0;
        forever begin
            @(negedge clock);
            #2;
            if (reset) hold_v = 0;
            else if (bus.outValid) begin
                chk("inReady while emitting", bus.inReady, 0);
                if (hold_v) chk("stalled token stable", {bus.outIsCount, bus.outTag, bus.outLast, bus.outData}, snap);
                if (bus.outReady) begin
                    hold_v = 0;
                    if (q.size() == 0) chk("spurious token", 1, 0);
                    else chk("token", {bus.outIsCount, bus.outTag, bus.outLast, bus.outData}, q.pop_front());
                end else begin
                    hold_v = 1;
                    snap = {bus.outIsCount, bus.outTag, bus.outLast, bus.outData};
                end
            end else hold_v = 0;
        end
    end

    initial begin
        logic [6:0] s;
        int r;
        bus.dataIn = '0;
        bus.inValid = 1'b0;
        bus.inLast = 1'b0;
        m_open = 0;
        m_cnt = 0;
        m_ch = '0;
        #12;
        chk("reset outValid", bus.outValid, 0);
        chk("reset outData", bus.outData, 0);
        chk("reset busy", bus.busy, 0);
        chk("reset outLast", bus.outLast, 0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("inReady after reset", bus.inReady, 1);
        // AAAB(last)
        send("A", 0); send("A", 0); send("A", 0); send("B", 1);
        drain();
        // six C at MAX_RUN=4
        for (int i = 0; i < 6; i++) send("C", i == 5);
        drain();
        // non-printable dropped mid-run
        send("D", 0); send(7'h05, 0); send("D", 1);
        drain();
        // single symbol frame
        send("Z", 1);
        drain();
        // non-printable last with no open run is ignored
        send(7'h03, 1);
        #3;
        chk("ignored last keeps idle", bus.busy, 0);
        // back-pressure in EMIT_CHAR
        ready_mode = 2;
        manual_ready = 1'b0;
        send("Q", 1);
        repeat (5) begin
            @(negedge clock);
            #1;
            chk("stall outValid", bus.outValid, 1);
        end
        @(negedge clock);
        manual_ready = 1'b1;
        drain();
        // reset during EMIT_COUNT
        manual_ready = 1'b0;
        send("A", 0); send("A", 0); send("A", 0); send("B", 1);
        @(negedge clock);
        manual_ready = 1'b1;
        @(negedge clock);
        manual_ready = 1'b0;
        #1;
        chk("in EMIT_COUNT", {bus.outValid, bus.outIsCount}, 2'b11);
        #4;
        reset = 1'b1;
        #1;
        chk("async reset outValid", bus.outValid, 0);
        chk("async reset busy", bus.busy, 0);
        q.delete();
        m_open = 0;
        @(negedge clock);
        reset = 1'b0;
        ready_mode = 0;
        send("E", 1);
        drain();
        // randomized stream with random back-pressure
        ready_mode = 1;
        for (int i = 0; i < 1200; i++) begin
            r = $urandom_range(0, 19);
            s = r < 2 ? 7'($urandom_range(0, 31)) : r < 17 ? 7'("A" + $urandom_range(0, 2)) : 7'($urandom_range(32, 127));
            send(s, $urandom_range(0, 9) == 0);
            repeat ($urandom_range(0, 2)) @(negedge clock);
        end
        send("A", 1);
        drain();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
